// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources, packet-granular.
// Latency: request in IDLE -> Tx_DV/Ack next cycle; watchdogs abort hung transfers or stalled owners.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int TIMEOUT_CLKS = 65535,
    parameter int HOLD_CLKS    = 10416
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [NUM_REQ-1:0]   i_Last,
    input  logic [8*NUM_REQ-1:0] i_Byte,
    output logic [NUM_REQ-1:0]   o_Ack,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy,
    output logic                 o_Timeout
);
    localparam int IW   = $clog2(NUM_REQ);
    localparam int MAXC = (TIMEOUT_CLKS > HOLD_CLKS) ? TIMEOUT_CLKS : HOLD_CLKS;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CLKS - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CLKS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, HOLD} state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       owner, owner_nx, ptr, ptr_nx, winner, idx, sel;
    logic                win_vld, last_q, timeout_nx, load_en;
    logic [NUM_REQ-1:0]  grant_nx;
    logic [CW-1:0]       cnt;
    logic [7:0]          byte_sel;

    // Rotating search starting just after the last owner.
    always_comb begin
        winner  = '0;
        win_vld = 1'b0;
        idx     = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
            if (!win_vld && i_Req[idx]) begin
                winner  = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        ptr_nx     = ptr;
        grant_nx   = o_Grant;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nx = LOAD;
                    owner_nx = winner;
                    grant_nx = NUM_REQ'(1) << winner;
                end
            end
            LOAD: state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (i_Tx_Done) begin
                    if (last_q) begin
                        state_nx = IDLE;
                        grant_nx = '0;
                        ptr_nx   = owner;
                    end else begin
                        state_nx = HOLD;
                    end
                end else if (cnt == TO_LAST) begin
                    state_nx   = IDLE;
                    grant_nx   = '0;
                    ptr_nx     = owner;
                    timeout_nx = 1'b1;
                end
            end
            HOLD: begin
                if (i_Req[owner]) begin
                    state_nx = LOAD;
                end else if (cnt == HOLD_LAST) begin
                    state_nx   = IDLE;
                    grant_nx   = '0;
                    ptr_nx     = owner;
                    timeout_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Byte is captured on the edge entering LOAD so it is valid alongside Tx_DV.
    always_comb begin
        sel      = (state == IDLE) ? winner : owner;
        load_en  = (state_nx == LOAD) && (state != LOAD);
        byte_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel == IW'(k)) byte_sel = i_Byte[8*k +: 8];
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= IW'(NUM_REQ - 1);
            o_Grant   <= '0;
            o_Tx_Byte <= '0;
            o_Timeout <= 1'b0;
            last_q    <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            ptr       <= ptr_nx;
            o_Grant   <= grant_nx;
            o_Timeout <= timeout_nx;
            if (load_en) o_Tx_Byte <= byte_sel;
            if (state == LOAD) last_q <= i_Last[owner];
            if ((state_nx != state) || (state == IDLE) || (state == LOAD))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    assign o_Tx_DV = (state == LOAD);
    assign o_Ack   = (state == LOAD) ? o_Grant : '0;
    assign o_Busy  = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with short watchdogs (TIMEOUT_CLKS=8, HOLD_CLKS=4).
module tb_uart_tx_arbiter;
    logic        i_Clock, i_Reset, i_Tx_Done;
    logic [1:0]  i_Req, i_Last, o_Ack, o_Grant;
    logic [15:0] i_Byte;
    logic        o_Tx_DV, o_Busy, o_Timeout;
    logic [7:0]  o_Tx_Byte;
    int          passes = 0;
    int          total  = 0;

    uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CLKS(8), .HOLD_CLKS(4)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Req(i_Req), .i_Last(i_Last),
        .i_Byte(i_Byte), .o_Ack(o_Ack), .o_Grant(o_Grant), .o_Tx_DV(o_Tx_DV),
        .o_Tx_Byte(o_Tx_Byte), .i_Tx_Done(i_Tx_Done), .o_Busy(o_Busy),
        .o_Timeout(o_Timeout)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    // From IDLE with a request pending: one single-byte packet to completion.
    task automatic single_pkt(input logic [1:0] g, input logic [7:0] b);
        tick();
        chk("pkt_dv", {7'd0, o_Tx_DV}, 8'd1);
        chk("pkt_ack", {6'd0, o_Ack}, {6'd0, g});
        chk("pkt_grant", {6'd0, o_Grant}, {6'd0, g});
        chk("pkt_byte", o_Tx_Byte, b);
        tick();
        chk("pkt_wait_dv", {7'd0, o_Tx_DV}, 8'd0);
        chk("pkt_wait_ack", {6'd0, o_Ack}, 8'd0);
        i_Tx_Done = 1'b1;
        tick();
        i_Tx_Done = 1'b0;
        chk("pkt_rel_grant", {6'd0, o_Grant}, 8'd0);
        chk("pkt_rel_busy", {7'd0, o_Busy}, 8'd0);
        chk("pkt_rel_to", {7'd0, o_Timeout}, 8'd0);
    endtask

    initial begin
        i_Reset = 1'b0; i_Req = 2'b00; i_Last = 2'b00; i_Byte = 16'h0000; i_Tx_Done = 1'b0;
        #2 i_Reset = 1'b1;
        tick(); tick();
        chk("rst_busy", {7'd0, o_Busy}, 8'd0);
        chk("rst_grant", {6'd0, o_Grant}, 8'd0);
        chk("rst_dv", {7'd0, o_Tx_DV}, 8'd0);
        chk("rst_byte", o_Tx_Byte, 8'd0);
        chk("rst_to", {7'd0, o_Timeout}, 8'd0);
        i_Reset = 1'b0;

        // Reset mid-WAIT_DONE
        i_Req = 2'b10; i_Last = 2'b11; i_Byte = {8'h5A, 8'hA5};
        tick();
        chk("mid_load_grant", {6'd0, o_Grant}, 8'h02);
        tick();
        chk("mid_wait_busy", {7'd0, o_Busy}, 8'd1);
        i_Reset = 1'b1;
        #1;
        chk("async_busy", {7'd0, o_Busy}, 8'd0);
        chk("async_grant", {6'd0, o_Grant}, 8'd0);
        chk("async_byte", o_Tx_Byte, 8'd0);
        chk("async_to", {7'd0, o_Timeout}, 8'd0);
        i_Req = 2'b11;
        tick();
        i_Reset = 1'b0;

        // Alternating single-byte packets, requester 0 first
        single_pkt(2'b01, 8'hA5);
        single_pkt(2'b10, 8'h5A);
        single_pkt(2'b01, 8'hA5);
        single_pkt(2'b10, 8'h5A);

        // Make requester 0 the last owner, then a 3-byte packet from requester 1
        i_Req = 2'b01;
        single_pkt(2'b01, 8'hA5);
        i_Req = 2'b11; i_Last = 2'b01; i_Byte = {8'h11, 8'hC3};
        tick();
        chk("m1_grant", {6'd0, o_Grant}, 8'h02);
        chk("m1_byte", o_Tx_Byte, 8'h11);
        tick();
        i_Tx_Done = 1'b1;
        tick();
        i_Tx_Done = 1'b0;
        i_Byte = {8'h22, 8'hC3};
        chk("m_hold_dv", {7'd0, o_Tx_DV}, 8'd0);
        chk("m_hold_grant", {6'd0, o_Grant}, 8'h02);
        tick();
        chk("m2_dv", {7'd0, o_Tx_DV}, 8'd1);
        chk("m2_ack", {6'd0, o_Ack}, 8'h02);
        chk("m2_byte", o_Tx_Byte, 8'h22);
        tick();
        i_Tx_Done = 1'b1;
        tick();
        i_Tx_Done = 1'b0;
        i_Byte = {8'h33, 8'hC3}; i_Last = 2'b11;
        tick();
        chk("m3_grant", {6'd0, o_Grant}, 8'h02);
        chk("m3_byte", o_Tx_Byte, 8'h33);
        tick();
        i_Tx_Done = 1'b1;
        tick();
        i_Tx_Done = 1'b0;
        chk("m_end_grant", {6'd0, o_Grant}, 8'd0);

        // Requester 0 served next; transmitter never finishes -> WAIT_DONE watchdog
        tick();
        chk("r0_grant", {6'd0, o_Grant}, 8'h01);
        chk("r0_byte", o_Tx_Byte, 8'hC3);
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("wd_no_early", {7'd0, o_Timeout}, 8'd0);
        end
        i_Byte = {8'h44, 8'hC3}; i_Last = 2'b01;
        tick();
        chk("wd_to", {7'd0, o_Timeout}, 8'd1);
        chk("wd_busy", {7'd0, o_Busy}, 8'd0);
        chk("wd_grant", {6'd0, o_Grant}, 8'd0);
        tick();
        chk("wd_pulse_end", {7'd0, o_Timeout}, 8'd0);
        chk("wd_next_grant", {6'd0, o_Grant}, 8'h02);
        chk("wd_next_byte", o_Tx_Byte, 8'h44);

        // Owner 1 stalls after a non-last byte -> HOLD watchdog; spurious done in HOLD
        i_Req = 2'b01;
        tick();
        i_Tx_Done = 1'b1;
        tick();
        chk("h_enter_to", {7'd0, o_Timeout}, 8'd0);
        tick();
        i_Tx_Done = 1'b0;
        chk("h_spur_busy", {7'd0, o_Busy}, 8'd1);
        chk("h_spur_dv", {7'd0, o_Tx_DV}, 8'd0);
        chk("h_spur_grant", {6'd0, o_Grant}, 8'h02);
        tick();
        tick();
        chk("h_no_early", {7'd0, o_Timeout}, 8'd0);
        i_Last = 2'b00;
        tick();
        chk("h_to", {7'd0, o_Timeout}, 8'd1);
        chk("h_grant", {6'd0, o_Grant}, 8'd0);

        // Second run: owner 0 returns in HOLD counter cycle 3
        tick();
        chk("h2_grant", {6'd0, o_Grant}, 8'h01);
        i_Req = 2'b00;
        tick();
        i_Tx_Done = 1'b1;
        tick();
        i_Tx_Done = 1'b0;
        tick(); tick(); tick();
        i_Req = 2'b01; i_Byte = {8'h44, 8'hD7}; i_Last = 2'b01;
        tick();
        chk("h2_reload_dv", {7'd0, o_Tx_DV}, 8'd1);
        chk("h2_reload_to", {7'd0, o_Timeout}, 8'd0);
        chk("h2_reload_byte", o_Tx_Byte, 8'hD7);
        i_Req = 2'b00;

        // Done coincides with timeout at counter 7
        tick();
        for (int i = 0; i < 7; i++) tick();
        i_Tx_Done = 1'b1;
        tick();
        i_Tx_Done = 1'b0;
        chk("co_to", {7'd0, o_Timeout}, 8'd0);
        chk("co_busy", {7'd0, o_Busy}, 8'd0);
        chk("co_grant", {6'd0, o_Grant}, 8'd0);

        // Spurious done in IDLE
        i_Tx_Done = 1'b1;
        tick();
        i_Tx_Done = 1'b0;
        chk("idle_spur_busy", {7'd0, o_Busy}, 8'd0);
        chk("idle_spur_dv", {7'd0, o_Tx_DV}, 8'd0);
        chk("idle_spur_to", {7'd0, o_Timeout}, 8'd0);
        chk("idle_hold_byte", o_Tx_Byte, 8'hD7);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (byte-strobe `o_Tx_DV`, active/done handshake) between `NUM_REQ` requesters.
- Round-robin grant per packet; the owner keeps the transmitter until it sends a byte flagged last, or goes idle too long.
- Watchdog timers recover from a hung transmitter or a stalled owner.
- Sits between the command/telemetry sources and the UART TX datapath.

Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `TIMEOUT_CLKS`, 65535: max cycles in WAIT_DONE before abort (≥2).
- `HOLD_CLKS`, 10416: max cycles the owner may idle between bytes of a packet (≥2).

Ports:
- `i_Clock`  in  1  system clock.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Req`  in  `NUM_REQ`  per-requester byte-valid, level, held until acked.
- `i_Last`  in  `NUM_REQ`  per-requester last-byte-of-packet flag, qualified by `i_Req`.
- `i_Byte`  in  8*`NUM_REQ`  requester k byte on bits [8k+7:8k].
- `o_Ack`  out  `NUM_REQ`  one-cycle pulse: byte of requester k accepted.
- `o_Grant`  out  `NUM_REQ`  one-hot current owner, 0 when free.
- `o_Tx_DV`  out  1  one-cycle start strobe to the transmitter.
- `o_Tx_Byte`  out  8  byte to transmit, registered.
- `i_Tx_Done`  in  1  transmitter done pulse (stop bit complete).
- `o_Busy`  out  1  high in every state except IDLE.
- `o_Timeout`  out  1  one-cycle pulse on watchdog abort (either timer).

Behaviour:
- Reset (async, immediate): state=IDLE; `o_Ack`=0, `o_Grant`=0, `o_Tx_DV`=0, `o_Tx_Byte`=0, `o_Busy`=0, `o_Timeout`=0; last-owner pointer=`NUM_REQ`-1, so requester 0 wins first; counters=0. Reset mid-transfer aborts silently, with no `o_Timeout`.
- States:
  - IDLE → LOAD when `i_Req` ≠ 0. Winner is the first requester with `i_Req` set, searching pointer+1, pointer+2, … modulo `NUM_REQ`. `o_Grant` is registered on the transition.
  - LOAD (exactly 1 cycle): `o_Tx_DV`=1; `o_Ack`[owner]=1; `o_Tx_Byte` loads owner byte on entry, so it is valid during LOAD; capture `i_Last`[owner]; → WAIT_DONE. `i_Tx_Done` ignored here.
  - WAIT_DONE: counter increments each cycle from 0.
    - `i_Tx_Done`=1 and captured last=1 → IDLE, `o_Grant`=0, pointer=owner.
    - `i_Tx_Done`=1 and captured last=0 → HOLD.
    - Else if counter = `TIMEOUT_CLKS`-1 → IDLE, `o_Timeout` pulse, grant released, pointer=owner.
    - Done wins over timeout in the same cycle.
  - HOLD: counter restarts at 0.
    - `i_Req`[owner]=1 → LOAD, same owner; other requesters are not considered.
    - Else if counter = `HOLD_CLKS`-1 → IDLE, `o_Timeout` pulse, release, pointer=owner.
    - Request wins over timeout in the same cycle.
- Latency: request seen in IDLE at cycle t → `o_Tx_DV`/`o_Ack` at t+1. Next byte of a packet: `i_Tx_Done` at t, `i_Req` held → HOLD at t+1, `o_Tx_DV` at t+2.
- `o_Tx_Byte` holds its value until the next LOAD. `o_Grant` is stable from LOAD through release. `o_Ack` is never asserted for a non-owner.
- `i_Tx_Done` outside WAIT_DONE is ignored. Requests arriving while busy wait; no request is lost while it is held high.
- Counter width is clog2(max(`TIMEOUT_CLKS`,`HOLD_CLKS`)+1) and never wraps: it resets on every state entry.

Test Plan:
1. Reset mid-WAIT_DONE → all outputs 0 immediately. After release, `i_Req`=2'b11 → requester 0 granted first, `o_Tx_Byte`=`i_Byte`[7:0] with `o_Tx_DV` one cycle later.
2. `NUM_REQ`=2, both requesting single-byte packets (`i_Last`=1) back-to-back, bytes 0xA5/0x5A → alternating grants 0,1,0,1; `o_Tx_Byte` sequence A5,5A,A5,5A; each `o_Ack` exactly one pulse per `i_Tx_Done`.
3. Requester 1 sends a 3-byte packet (11,22,33, last on 33) while requester 0 requests throughout → grant stays 01→`o_Grant`=2'b10 for all three bytes; requester 0 is served only after the 0x33 done.
4. `TIMEOUT_CLKS`=8, `i_Tx_Done` never asserted → `o_Timeout` pulse exactly 8 cycles after entering WAIT_DONE; state IDLE; next grant goes to the other pending requester.
5. `HOLD_CLKS`=4, owner drops `i_Req` after a non-last byte → `o_Timeout` 4 cycles after entering HOLD, grant released. Second run: `i_Req` reasserted in counter cycle 3 → LOAD, no timeout.
6. `i_Tx_Done` and timeout coincide (done at counter=`TIMEOUT_CLKS`-1) → no `o_Timeout`, normal completion. Spurious `i_Tx_Done` in IDLE/HOLD → no state change.
